// File: rtl/redstone_pkg.sv
// Shared types and constants for the redstone game-tick controller.
package redstone_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } tick_state_t;

   localparam int TICK_DIV_DEFAULT = 4;
   localparam int STEP_CNT_W       = 16;
   localparam int DIV_W            = 16;

   typedef struct packed {
      logic                  valid;
      logic [STEP_CNT_W-1:0] count;
   } step_req_t;

   // A divide-by-N tick needs the counter loaded with N-1.
   function automatic logic [DIV_W-1:0] div_reload(input int div);
      return DIV_W'(div - 1);
   endfunction

endpackage

// File: rtl/redstone_tick_div.sv
// Loadable down-counter with a registered one-cycle terminal pulse.
module redstone_tick_div
   import redstone_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_reload,
   input  logic         i_en,
   output logic         o_term,
   output logic         o_tick
);

   logic [W-1:0] cnt;

   // o_term lets the owner act on the same edge that registers o_tick.
   assign o_term = i_en && (cnt == '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt    <= '0;
         o_tick <= 1'b0;
      end else begin
         o_tick <= o_term;
         if (i_load)
            cnt <= i_reload;
         else if (i_en)
            cnt <= (cnt == '0) ? i_reload : cnt - 1'b1;
      end
   end

endmodule

// File: rtl/redstone_tick_ctrl.sv
// Redstone game-tick generator: free-running RUN or counted STEP bursts.
// Optional macro REDSTONE_TICK_FAST_EN enables i_fast (tick every 2 cycles).
module redstone_tick_ctrl
   import redstone_pkg::*;
#(
   parameter int DIV   = TICK_DIV_DEFAULT,
   parameter int CNT_W = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_run,
   input  logic                  i_step_valid,
   input  logic [STEP_CNT_W-1:0] i_step_count,
   output logic                  o_step_ready,
   output logic                  o_step_done,
   input  logic                  i_fast,
   output logic                  o_tick,
   output logic [CNT_W-1:0]      o_tick_count,
   output logic                  o_busy
);

   tick_state_t           state, state_nxt;
   logic [STEP_CNT_W-1:0] remaining, rem_nxt;
   logic                  done_nxt;
   logic                  div_load, div_en, div_term;
   logic [DIV_W-1:0]      div_val, reload;
   step_req_t             req;

   assign req = '{valid: i_step_valid, count: i_step_count};

`ifdef REDSTONE_TICK_FAST_EN
   assign reload = i_fast ? DIV_W'(1) : div_reload(DIV);
`else
   logic unused_fast;
   assign unused_fast = i_fast;
   assign reload      = div_reload(DIV);
`endif

   redstone_tick_div #(.W(DIV_W)) u_div (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_load   (div_load),
      .i_reload (div_val),
      .i_en     (div_en),
      .o_term   (div_term),
      .o_tick   (o_tick)
   );

   always_comb begin
      state_nxt = state;
      rem_nxt   = remaining;
      done_nxt  = 1'b0;
      div_load  = 1'b0;
      div_val   = reload;
      div_en    = 1'b0;
      case (state)
         IDLE: begin
            if (req.valid && o_step_ready) begin
               if (req.count != '0) begin
                  state_nxt = STEP;
                  rem_nxt   = req.count;
                  div_load  = 1'b1;
               end else begin
                  done_nxt  = 1'b1;
               end
            end else if (i_run) begin
               state_nxt = RUN;
               div_load  = 1'b1;
            end
         end
         RUN: begin
            // Keep enable on during exit so a tick due this edge still fires.
            div_en = 1'b1;
            if (!i_run) begin
               state_nxt = IDLE;
               div_load  = 1'b1;
               div_val   = '0;
            end
         end
         STEP: begin
            if (remaining == '0) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
               div_load  = 1'b1;
               div_val   = '0;
            end else begin
               div_en = 1'b1;
               if (div_term)
                  rem_nxt = remaining - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= IDLE;
         remaining    <= '0;
         o_tick_count <= '0;
         o_step_ready <= 1'b0;
         o_step_done  <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         state        <= state_nxt;
         remaining    <= rem_nxt;
         o_step_done  <= done_nxt;
         o_step_ready <= (state_nxt == IDLE);
         o_busy       <= (state_nxt != IDLE);
         if (div_term)
            o_tick_count <= o_tick_count + CNT_W'(1);
      end
   end

endmodule
